// File: rtl/lab_vector_driver.sv
// Walks all 16 input vectors onto a 4-input combinational block, samples out1
// after a settle interval and scores it against the EXPECT truth table.
module lab_vector_driver #(
  parameter logic [15:0] EXPECT = 16'h28AC,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       out1,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       fail_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_CNT = SETTLE[3:0];

  logic [1:0] state, state_n;
  logic [3:0] vec, vec_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] err_n;
  logic [3:0] first_n;
  logic       fv_n;
  logic       busy_n, done_n, pass_n;
  logic       mismatch;

  // Vector bits come straight from the vec register so they only move on a clock edge.
  assign in1 = vec[3];
  assign in2 = vec[2];
  assign in3 = vec[1];
  assign in4 = vec[0];

  // Next-state and result computation for the sweep sequencer.
  always_comb begin
    state_n  = state;
    vec_n    = vec;
    cnt_n    = cnt;
    err_n    = err_count;
    first_n  = first_fail;
    fv_n     = fail_valid;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    mismatch = out1 ^ EXPECT[vec];
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_SETTLE;
          vec_n   = 4'd0;
          cnt_n   = SETTLE_CNT;
          err_n   = 5'd0;
          first_n = 4'd0;
          fv_n    = 1'b0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end else begin
          state_n = state;
        end
      end
      S_SETTLE: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = S_SAMPLE;
        end else begin
          state_n = S_SETTLE;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_n = err_count + 5'd1;
          if (!fail_valid) begin
            first_n = vec;
            fv_n    = 1'b1;
          end else begin
            first_n = first_fail;
          end
        end else begin
          err_n = err_count;
        end
        // Pass is decided from the final count, including this last sample.
        if (vec == 4'd15) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == 5'd0);
        end else begin
          vec_n   = vec + 4'd1;
          cnt_n   = SETTLE_CNT;
          state_n = S_SETTLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        vec_n   = 4'd0;
        cnt_n   = 4'd0;
        err_n   = 5'd0;
        first_n = 4'd0;
        fv_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        pass_n  = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec        <= 4'd0;
      cnt        <= 4'd0;
      err_count  <= 5'd0;
      first_fail <= 4'd0;
      fail_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      cnt        <= cnt_n;
      err_count  <= err_n;
      first_fail <= first_n;
      fail_valid <= fv_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
    end
  end

endmodule

// File: tb/tb_lab_vector_driver.sv
// Scoreboard bench: three driver instances (SETTLE 2, 1, 4) against a modelled
// combinational block with an optional 3-cycle output delay.
module tb_lab_vector_driver;

  localparam logic [15:0] EXP = 16'h28AC;

  function automatic int st_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int         sel;
    logic [4:0] err;
    logic [3:0] first;
    logic       fv;
    logic       pass;
    int         c0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start = 3'b000;
  logic [2:0] out1;
  logic [2:0][3:0] vec;
  logic [2:0] busy, done, pass, fail_valid;
  logic [2:0][4:0] err;
  logic [2:0][3:0] ff;
  logic [15:0] dev_tab = EXP;
  int dly = 0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int act_sel = 0;
  int act_c0 = 0;
  bit act_on = 1'b0;
  logic [2:0] done_prev = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    logic [3:0] d1, d2, d3;
    lab_vector_driver #(.EXPECT(EXP), .SETTLE(st_of(g))) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .out1(out1[g]),
      .in1(vec[g][3]), .in2(vec[g][2]), .in3(vec[g][1]), .in4(vec[g][0]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_count(err[g]), .first_fail(ff[g]), .fail_valid(fail_valid[g])
    );
    always @(posedge clk) begin
      d1 <= vec[g];
      d2 <= d1;
      d3 <= d2;
    end
    assign out1[g] = (dly == 3) ? dev_tab[d3] : dev_tab[vec[g]];
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: vector v occupies cycles v*(S+1)..v*(S+1)+S after the start edge and
  // is sampled in its last cycle; a delayed block shows the vector of cycle t-dly.
  function automatic exp_t model(input int sel, input logic [15:0] tab, input int d,
                                 input int pre, input int c0);
    exp_t r;
    int s;
    s = st_of(sel);
    r.sel = sel; r.err = 5'd0; r.first = 4'd0; r.fv = 1'b0; r.c0 = c0;
    for (int v = 0; v < 16; v++) begin
      int idx, seen;
      idx = v * (s + 1) + s - d;
      seen = (idx < 0) ? pre : idx / (s + 1);
      if (tab[seen] != EXP[v]) begin
        if (!r.fv) begin
          r.first = v[3:0];
          r.fv = 1'b1;
        end
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (r.err == 5'd0);
    return r;
  endfunction

  task automatic launch(input int sel, input int pre);
    @(negedge clk);
    start[sel] = 1'b1;
    @(posedge clk);
    #1;
    start[sel] = 1'b0;
    sb.push_back(model(sel, dev_tab, dly, pre, cyc));
    act_sel = sel;
    act_c0 = cyc;
    act_on = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sweep_timeout: done not seen within %0d cycles", budget);
      sb.delete();
      act_on = 1'b0;
    end
    repeat (4) @(posedge clk);
  endtask

  // Monitor: per-cycle vector/busy tracking and scoreboard pop on each done rise.
  initial begin
    forever begin
      @(negedge clk);
      if (act_on && rst_n) begin
        int j, s;
        j = cyc - act_c0;
        s = st_of(act_sel);
        if (j < 16 * (s + 1)) begin
          chk("vec_step", vec[act_sel], j / (s + 1));
          chk("busy_sweep", busy[act_sel], 1);
        end
      end
      for (int g = 0; g < 3; g++) begin
        if (done[g] && !done_prev[g]) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", g, -1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_inst", g, e.sel);
            chk("done_latency", cyc - e.c0, 16 * (st_of(g) + 1));
            chk("err_count", err[g], e.err);
            chk("first_fail", ff[g], e.first);
            chk("fail_valid", fail_valid[g], e.fv);
            chk("pass", pass[g], e.pass);
            chk("busy_done", busy[g], 0);
            if (act_sel == g) act_on = 1'b0;
          end
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_vec", vec[g], 0);
      chk("rst_flags", {busy[g], done[g], pass[g], fail_valid[g]}, 0);
      chk("rst_err", err[g], 0);
      chk("rst_first", ff[g], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    dev_tab = EXP;
    launch(0, 0);
    wait_idle(200);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done[0], 1);

    dev_tab = 16'h0000;
    launch(0, 15);
    wait_idle(200);

    dev_tab = ~EXP;
    launch(0, 15);
    wait_idle(200);

    dev_tab = EXP;
    launch(0, 15);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start[0] = 1'b1;
    repeat (2) @(negedge clk);
    start[0] = 1'b0;
    wait_idle(200);

    for (int k = 0; k < 4; k++) begin
      dev_tab = 16'($urandom);
      launch(0, 15);
      wait_idle(200);
    end

    dev_tab = EXP;
    launch(0, 15);
    for (int n = 0; n < 200 && vec[0] != 4'd7; n++) @(negedge clk);
    chk("reach_vec7", vec[0], 7);
    act_on = 1'b0;
    sb.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vec", vec[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_done", done[0], 0);
    chk("midrst_err", err[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    launch(0, 0);
    wait_idle(200);

    dev_tab = EXP ^ 16'h0101;
    launch(1, 0);
    wait_idle(200);
    dev_tab = EXP;
    launch(1, 15);
    chk("restart_done", done[1], 0);
    chk("restart_err", err[1], 0);
    chk("restart_fv", fail_valid[1], 0);
    chk("restart_busy", busy[1], 1);
    wait_idle(200);

    dly = 3;
    dev_tab = EXP;
    launch(2, 0);
    wait_idle(200);
    launch(0, 15);
    wait_idle(200);
    chk("delay_s2_errpos", (err[0] > 5'd0) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lab_vector_driver.md
Name: lab_vector_driver

Overview:
- Self-checking stimulus stage that sits directly upstream of the lab 4-input combinational function block.
- On a start pulse it walks all 16 input combinations onto in1..in4 and waits a settle interval per vector.
- It samples the block's out1 for each vector and compares it against a parameterised truth table.
- It reports a mismatch count, the first failing vector, and a pass flag, so the combinational stage can be exercised on the board or in simulation without a hand-written table.

Parameters:
- EXPECT, 16'h28AC, expected out1 per vector; bit index = {in1,in2,in3,in4}. Default is the lab function, true at indices 2,3,5,7,11,13.
- SETTLE, 2, cycles each vector is held before out1 is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a full 16-vector sweep; sampled only in IDLE or DONE
- out1  input  1  function output returned from the combinational block
- in1  output  1  vector bit 3 (MSB) to the combinational block
- in2  output  1  vector bit 2
- in3  output  1  vector bit 1
- in4  output  1  vector bit 0 (LSB)
- busy  output  1  high in SETTLE and SAMPLE
- done  output  1  high in DONE; held until the next start or reset
- pass  output  1  in DONE, high iff err_count==0; low in all other states
- err_count  output  5  number of mismatching vectors, 0..16
- first_fail  output  4  index of the first mismatching vector
- fail_valid  output  1  first_fail holds a valid index

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-sweep) forces:
  - state=IDLE, vec=0, so in1..in4=0
  - busy=0, done=0, pass=0
  - err_count=0, first_fail=0, fail_valid=0
- in1..in4 are driven directly from the 4-bit vec register: glitch-free, and they change only on a clock edge.
- State machine, states IDLE, SETTLE, SAMPLE, DONE:
  - IDLE: on start=1, load vec<=0, cnt<=SETTLE, clear err_count, first_fail and fail_valid, then go to SETTLE.
  - SETTLE: cnt decrements each cycle. When cnt==1, go to SAMPLE. This holds each vector for exactly SETTLE cycles.
  - SAMPLE, one cycle: mismatch = out1 XOR EXPECT[vec].
    - On mismatch, err_count increments.
    - If fail_valid==0, set first_fail<=vec and fail_valid<=1.
    - If vec==15, go to DONE with vec held at 15.
    - Otherwise vec<=vec+1, cnt<=SETTLE, go to SETTLE.
  - DONE: done=1, and pass is valid. On start=1, behave exactly as IDLE+start (restart the sweep and clear results).
- start is ignored while busy; there is no abort other than rst_n.
- Latency: the sweep takes 16*(SETTLE+1) cycles. If start is seen at edge 0, done rises after edge 16*(SETTLE+1); with the default SETTLE=2 that is edge 48.
- out1 is sampled only in SAMPLE. Its value in every other state has no effect, including X during reset.
- err_count saturation is unnecessary, since the maximum is 16 and fits in 5 bits. vec never wraps within a sweep.
- first_fail, err_count and fail_valid hold their values in DONE until the next start or reset.
- A start pulse longer than one cycle behaves as a single start, because it is ignored once busy.

Test Plan:
- Good DUT: connect the lab function with default parameters and pulse start. Expect in1..in4 to step 0..15 with each held 3 cycles, done at start+48, pass=1, err_count=0, fail_valid=0.
- Stuck-at-0: tie out1=0. Expect done at start+48, pass=0, err_count=6, first_fail=2, fail_valid=1.
- Inverted DUT: drive out1=~function. Expect err_count=16, first_fail=0, pass=0.
- Reset mid-sweep: assert rst_n low while vec=7 in SETTLE. Expect in1..in4=0, busy=0, done=0 and err_count=0 immediately, without waiting for a clock. After release, a start gives a full clean sweep with pass=1.
- Start handling: pulse start at sweep cycle 10. Expect no effect and done still at start+48. Pulse start in DONE. Expect done=0, results cleared and a new sweep, with SETTLE=1 giving done at +32.
- Settle sampling: use SETTLE=4 with a DUT model delayed 3 cycles. Expect pass=1. With SETTLE=2 the same DUT yields err_count>0.
